// File: rtl/screen_seq_pkg.sv
// Shared encodings for the screen sequencer: top-level screens, pet
// expressions, pixel source indices and menu entries.
package screen_seq_pkg;

  typedef enum logic [2:0] {
    TOP_EXPRESSION = 3'd0,
    TOP_MENU       = 3'd1,
    TOP_SETTING    = 3'd2,
    TOP_GAME       = 3'd3,
    TOP_POTATO     = 3'd4,
    TOP_FINISH     = 3'd5
  } top_state_t;

  // Expression codes double as their pixel source index.
  typedef enum logic [2:0] {
    EXPR_IDLE    = 3'd0,
    EXPR_HAPPY   = 3'd1,
    EXPR_SATISFY = 3'd2,
    EXPR_SLEEP   = 3'd3,
    EXPR_EXPECT  = 3'd4
  } express_t;

  localparam int SRC_IDLE    = 0;
  localparam int SRC_HAPPY   = 1;
  localparam int SRC_SATISFY = 2;
  localparam int SRC_SLEEP   = 3;
  localparam int SRC_EXPECT  = 4;
  localparam int SRC_MENU    = 5;
  localparam int SRC_SETTING = 6;
  localparam int SRC_POTATO  = 7;

  localparam logic [1:0] MODE_GAME    = 2'd0;
  localparam logic [1:0] MODE_POTATO  = 2'd1;
  localparam logic [1:0] MODE_SETTING = 2'd2;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Pixel bus between the image sources / LCD scanner and the sequencer.
// master: source side (drives pixels and frame timing); slave: sequencer.
interface screen_sequencer_if #(
  parameter int PIX_W = 16,
  parameter int N_SRC = 8,
  parameter int SEL_W = 3
);
  logic [N_SRC*PIX_W-1:0] src_data;
  logic                   frame_start;
  logic [PIX_W-1:0]       pix_out;
  logic [SEL_W:0]         shown_src;

  modport master (output src_data, frame_start, input pix_out, shown_src);
  modport slave  (input src_data, frame_start, output pix_out, shown_src);
endinterface

// File: rtl/screen_sequencer_tick_timeout_counter.sv
// Counts tick enables while en is high and saturates at LIMIT; done is
// high once the count has reached LIMIT. clr wins over a same-cycle tick.
module tick_timeout_counter #(
  parameter int LIMIT = 10,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic en,
  input  logic clr,
  output logic done
);
  logic [W-1:0] cnt_reg;

  assign done = (cnt_reg == W'(LIMIT));

  // Saturating tick counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en && tick && !done) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end
endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: top screen FSM, pet expression FSM, menu cursor and a
// registered pixel mux onto the LCD bus.
// Optional macro SCREEN_TEARFREE_EN: the displayed source only switches on
// frame_start, so the LCD never shows a partly switched frame.
module screen_sequencer
  import screen_seq_pkg::*;
#(
  parameter int PIX_W        = 16,
  parameter int N_SRC        = 8,
  parameter int SEL_W        = 3,
  parameter int TICK_DIV     = 50000000,
  parameter int EXPR_TIMEOUT = 10,
  parameter int MENU_TIMEOUT = 10,
  parameter int N_MODES      = 3,
  parameter logic [PIX_W-1:0] GAME_COLOR = PIX_W'(16'h5555)
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic awaking,
  input  logic touched,
  input  logic expecting,
  input  logic petting,
  input  logic pressed,
  input  logic left,
  input  logic right,
  input  logic finish,
  screen_sequencer_if.slave pix,
  output logic [2:0] top_state,
  output logic [2:0] express,
  output logic [1:0] mode,
  output logic start_potato,
  output logic start_setting,
  output logic start_gaming
);
  localparam int TICK_W = clog2_min1(TICK_DIV);
  localparam int EW     = clog2_min1(EXPR_TIMEOUT + 1);
  localparam int MW     = clog2_min1(MENU_TIMEOUT + 1);

  logic [TICK_W-1:0] tick_cnt_reg;
  logic              tick;
  top_state_t        top_reg, top_next;
  express_t          expr_reg, expr_next;
  logic [1:0]        mode_reg, mode_next;
  logic              consumed, press_eff;
  logic              expr_en, expr_clr, expr_to;
  logic              menu_en, menu_clr, menu_to;
  logic [SEL_W:0]    src_req;
  logic [SEL_W:0]    shown_src_reg;
  logic [PIX_W-1:0]  pix_out_reg;
  logic [PIX_W-1:0]  src_arr [N_SRC];

  assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

  // Free-running timebase; tick marks each wrap.
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt_reg <= '0;
    else             tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
  end

  // Top screen next state; a pressed that moves the screen is consumed.
  always_comb begin
    top_next = top_reg;
    consumed = 1'b0;
    case (top_reg)
      TOP_EXPRESSION: if (pressed) begin top_next = TOP_MENU; consumed = 1'b1; end
      TOP_MENU: begin
        if (menu_to) begin
          top_next = TOP_EXPRESSION;
        end else if (pressed) begin
          consumed = 1'b1;
          case (mode_reg)
            MODE_GAME:    top_next = TOP_GAME;
            MODE_POTATO:  top_next = TOP_POTATO;
            MODE_SETTING: top_next = TOP_SETTING;
            default:      consumed = 1'b0;
          endcase
        end
      end
      TOP_SETTING, TOP_GAME: if (pressed) begin top_next = TOP_MENU; consumed = 1'b1; end
      TOP_POTATO:     if (finish)  top_next = TOP_FINISH;
      TOP_FINISH:     if (menu_to) top_next = TOP_MENU;
      default:        top_next = TOP_EXPRESSION;
    endcase
  end

  // Expression next state; frozen outside EXPRESSION and on a consumed press.
  always_comb begin
    expr_next = expr_reg;
    press_eff = pressed && !consumed;
    if (top_reg == TOP_EXPRESSION && !consumed) begin
      case (expr_reg)
        EXPR_IDLE: begin
          if (expr_to)               expr_next = EXPR_SLEEP;
          else if (expecting)        expr_next = EXPR_EXPECT;
          else if (touched || go)    expr_next = EXPR_HAPPY;
        end
        EXPR_HAPPY:   if (go || !touched) expr_next = EXPR_IDLE;
        EXPR_SATISFY: if (!petting)       expr_next = EXPR_EXPECT;
        EXPR_SLEEP:   if (awaking)        expr_next = EXPR_IDLE;
        EXPR_EXPECT: begin
          if (!expecting || press_eff) expr_next = EXPR_IDLE;
          else if (petting)            expr_next = EXPR_SATISFY;
        end
        default: expr_next = EXPR_IDLE;
      endcase
    end
  end

  // Menu cursor with wrap; opposing buttons cancel.
  always_comb begin
    mode_next = mode_reg;
    if (top_reg == TOP_MENU && (left ^ right)) begin
      if (right) mode_next = (mode_reg == 2'(N_MODES - 1)) ? 2'd0 : mode_reg + 2'd1;
      else       mode_next = (mode_reg == 2'd0) ? 2'(N_MODES - 1) : mode_reg - 2'd1;
    end
  end

  assign expr_en  = (top_reg == TOP_EXPRESSION) && (expr_reg == EXPR_IDLE);
  assign expr_clr = !expr_en;
  assign menu_en  = (top_reg == TOP_MENU) || (top_reg == TOP_FINISH);
  assign menu_clr = (top_next != top_reg) ||
                    ((top_reg == TOP_MENU) && (left || right || pressed));

  tick_timeout_counter #(.LIMIT(EXPR_TIMEOUT), .W(EW)) u_expr_timer (
    .clk(clk), .rst(rst), .tick(tick), .en(expr_en), .clr(expr_clr), .done(expr_to)
  );

  tick_timeout_counter #(.LIMIT(MENU_TIMEOUT), .W(MW)) u_menu_timer (
    .clk(clk), .rst(rst), .tick(tick), .en(menu_en), .clr(menu_clr), .done(menu_to)
  );

  // State, expression and cursor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_reg  <= TOP_EXPRESSION;
      expr_reg <= EXPR_IDLE;
      mode_reg <= 2'd0;
    end else begin
      top_reg  <= top_next;
      expr_reg <= expr_next;
      mode_reg <= mode_next;
    end
  end

  // Source wanted by the current screen; N_SRC selects the game fill.
  always_comb begin
    src_req = '0;
    case (top_reg)
      TOP_EXPRESSION: src_req = (SEL_W+1)'(expr_reg);
      TOP_MENU:       src_req = (SEL_W+1)'(SRC_MENU);
      TOP_SETTING:    src_req = (SEL_W+1)'(SRC_SETTING);
      TOP_POTATO:     src_req = (SEL_W+1)'(SRC_POTATO);
      TOP_FINISH:     src_req = (SEL_W+1)'(SRC_HAPPY);
      TOP_GAME:       src_req = (SEL_W+1)'(N_SRC);
      default:        src_req = '0;
    endcase
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src_arr[gi] = pix.src_data[gi*PIX_W +: PIX_W];
  end

  // Displayed source latch and registered pixel mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      shown_src_reg <= '0;
      pix_out_reg   <= '0;
    end else begin
`ifdef SCREEN_TEARFREE_EN
      if (pix.frame_start) shown_src_reg <= src_req;
`else
      shown_src_reg <= src_req;
`endif
      pix_out_reg <= (shown_src_reg == (SEL_W+1)'(N_SRC)) ? GAME_COLOR
                                                          : src_arr[shown_src_reg[SEL_W-1:0]];
    end
  end

  assign pix.pix_out    = pix_out_reg;
  assign pix.shown_src  = shown_src_reg;
  assign top_state      = top_reg;
  assign express        = expr_reg;
  assign mode           = mode_reg;
  assign start_potato   = (top_reg == TOP_POTATO);
  assign start_setting  = (top_reg == TOP_SETTING);
  assign start_gaming   = (top_reg == TOP_GAME);
endmodule
